// File: rtl/btn_pkg.sv
// btn_pkg: shared channel state encoding and counter sizing for the button event front end.
package btn_pkg;
   typedef enum logic [1:0] {REL, PRESS_PEND, HELD, REL_PEND} btn_state_e;
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a > b ? a : b;
      m = m > c ? m : c;
      return $clog2(m) + 1;
   endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel (2-flop sync, polarity, debounce FSM, press pulse).
// Auto-repeat while held is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic pulse,
   output logic fire
);
   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   btn_state_e state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0] sync;
   logic s;
   assign s = sync[1] ^ ACTIVE_LOW;
`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
   logic rep, rep_nxt;
   always_ff @(posedge clk) rep <= rst ? 1'b0 : rep_nxt;
`endif
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fire      = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_nxt   = (state == HELD) & rep;
`endif
      unique case (state)
         REL: begin
            if (s) begin
               state_nxt = PRESS_PEND;
               cnt_nxt   = ONE;
            end
         end
         PRESS_PEND: begin
            if (!s) begin
               state_nxt = REL;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
               fire      = 1'b1;
            end else cnt_nxt = cnt + ONE;
         end
         HELD: begin
            if (!s) begin
               state_nxt = REL_PEND;
               cnt_nxt   = ONE;
            end
`ifdef BTN_AUTO_REPEAT_EN
            else if (cnt == (rep ? RP_LAST : RD_LAST)) begin
               cnt_nxt = '0;
               rep_nxt = 1'b1;
               fire    = 1'b1;
            end else cnt_nxt = cnt + ONE;
`endif
         end
         REL_PEND: begin
            if (s) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt = REL;
               cnt_nxt   = '0;
            end else cnt_nxt = cnt + ONE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= {2{ACTIVE_LOW}};
         state <= REL;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= (state_nxt == HELD) || (state_nxt == REL_PEND);
         pulse <= fire;
      end
   end
endmodule

// File: rtl/button_event_gen.sv
// button_event_gen: debounced press events for NUM_BTN buttons plus a combined event flag.
// Define BTN_AUTO_REPEAT_EN to re-fire events while a button stays held.
module button_event_gen
   import btn_pkg::*;
#(
   parameter int NUM_BTN         = 12,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] event_pulse,
   output logic [NUM_BTN-1:0] btn_level,
   output logic               event_any
);
   logic [NUM_BTN-1:0] fire;
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clk  (CLK),
         .rst  (RST),
         .raw  (btn_raw[i]),
         .level(btn_level[i]),
         .pulse(event_pulse[i]),
         .fire (fire[i])
      );
   end
   always_ff @(posedge CLK) event_any <= RST ? 1'b0 : |fire;
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: directed stimulus with a per-cycle behavioural model check.
module tb_button_event_gen;
   localparam int NUM_BTN = 12, D = 4, RD = 10, RP = 3;
   logic clk = 1'b0, rst = 1'b1;
   logic [NUM_BTN-1:0] btn_raw = '1;
   logic [NUM_BTN-1:0] event_pulse, btn_level;
   logic event_any;
   int n_cmp = 0, n_bad = 0;
   logic started = 1'b0;
   logic [NUM_BTN-1:0] h1, h2, m_level, m_pulse;
   logic m_any;
   int run [NUM_BTN];
   int age [NUM_BTN];
   logic [63:0] mask;

   button_event_gen #(
      .NUM_BTN(NUM_BTN), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .CLK(clk), .RST(rst), .btn_raw(btn_raw),
      .event_pulse(event_pulse), .btn_level(btn_level), .event_any(event_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic outs(input string tag, input logic [NUM_BTN-1:0] p, input logic [NUM_BTN-1:0] l, input logic a);
      check({tag, "_pulse"}, 64'(event_pulse), 64'(p));
      check({tag, "_level"}, 64'(btn_level), 64'(l));
      check({tag, "_any"}, 64'(event_any), 64'(a));
   endtask

   // Level follows the input seen two edges late once it has disagreed for D edges in a row.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         h1 = '0; h2 = '0; m_level = '0; m_pulse = '0; m_any = 1'b0; started = 1'b1;
         for (int k = 0; k < NUM_BTN; k++) begin
            run[k] = 0;
            age[k] = 0;
         end
      end else begin
         for (int k = 0; k < NUM_BTN; k++) begin
            m_pulse[k] = 1'b0;
            if (h2[k] != m_level[k]) begin
               run[k]++;
               if (run[k] == D) begin
                  m_level[k] = h2[k];
                  m_pulse[k] = h2[k];
                  run[k] = 0;
                  age[k] = 0;
               end
            end else begin
               if (m_level[k]) begin
                  age[k] = run[k] > 0 ? 0 : age[k] + 1;
`ifdef BTN_AUTO_REPEAT_EN
                  m_pulse[k] = age[k] >= RD && (age[k] - RD) % RP == 0;
`endif
               end
               run[k] = 0;
            end
         end
         m_any = |m_pulse;
         h2 = h1;
         h1 = ~btn_raw;
      end
   end

   initial forever begin
      @(negedge clk);
      if (started) begin
         check("cyc_pulse", 64'(event_pulse), 64'(m_pulse));
         check("cyc_level", 64'(btn_level), 64'(m_level));
         check("cyc_any", 64'(event_any), 64'(m_any));
      end
   end

   initial begin
      step(3);
      outs("reset", '0, '0, 1'b0);
      rst = 1'b0;
      step(3);
      btn_raw[5] = 1'b0;
      step(5); outs("press_pre", '0, '0, 1'b0);
      step(1); outs("press", 12'h020, 12'h020, 1'b1);
      check("model_press", 64'(m_pulse), 64'h020);
      step(1); outs("press_post", '0, 12'h020, 1'b0);
      btn_raw[5] = 1'b1;
      step(12); outs("release5", '0, '0, 1'b0);
      btn_raw[7] = 1'b0;
      step(3);
      btn_raw[7] = 1'b1;
      step(10); outs("glitch", '0, '0, 1'b0);
      btn_raw[9] = 1'b0;
      btn_raw[11] = 1'b0;
      step(6); outs("simul", 12'hA00, 12'hA00, 1'b1);
      check("model_any", 64'(m_any), 64'd1);
      step(1); outs("simul_post", '0, 12'hA00, 1'b0);
      btn_raw[9] = 1'b1;
      step(2);
      btn_raw[9] = 1'b0;
      step(8); outs("bounce", '0, 12'hA00, 1'b0);
      btn_raw[9] = 1'b1;
      btn_raw[11] = 1'b1;
      step(5); check("rel_pre", 64'(btn_level), 64'hA00);
      step(1); check("rel", 64'(btn_level), 64'h000);
      step(4);
      btn_raw[5] = 1'b0;
      step(8); check("held5", 64'(btn_level), 64'h020);
      rst = 1'b1;
      step(1); outs("rst1", '0, '0, 1'b0);
      step(1); outs("rst2", '0, '0, 1'b0);
      rst = 1'b0;
      step(5); outs("rst_pre", '0, '0, 1'b0);
      step(1); outs("rst_ev", 12'h020, 12'h020, 1'b1);
      step(1); outs("rst_post", '0, 12'h020, 1'b0);
      btn_raw[5] = 1'b1;
      step(12);
      mask = '0;
      btn_raw[5] = 1'b0;
      for (int j = 1; j < 46; j++) begin
         step(1);
         mask[j] = event_pulse[5];
         if (j == 30) btn_raw[5] = 1'b1;
      end
`ifdef BTN_AUTO_REPEAT_EN
      check("hold_events", mask, 64'h0000_0000_9249_0040);
`else
      check("hold_events", mask, 64'h0000_0000_0000_0040);
`endif
      outs("final", '0, '0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
